// File: rtl/fetch_queue_unit_pkg.sv
// Shared constants for the fetch queue unit
// and its prefetch buffer.
package fetch_queue_unit_pkg;
   localparam int unsigned XLEN_DEF    = 64;
   localparam int unsigned ILEN_DEF    = 32;
   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
endpackage

// File: rtl/fetch_queue_unit_sync_fifo.sv
// Registered circular buffer with flush and
// occupancy output; head entry is always visible.
module fetch_queue_unit_sync_fifo
   import fetch_queue_unit_pkg::*;
#(
   parameter int unsigned WIDTH = ILEN_DEF + XLEN_DEF,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] occ
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    occ_q, occ_d;
   logic             full, do_push, do_pop;

   assign full    = (occ_q == CW'(DEPTH));
   assign do_pop  = pop & (occ_q != '0) & ~flush;
   // a full queue still accepts a write when the head leaves
   assign do_push = push & ~flush & (~full | do_pop);

   always_comb begin
      mem_d  = mem_q;
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q + CW'(do_push) - CW'(do_pop);
      if (do_push) begin
         mem_d[tail_q] = wdata;
         tail_d = (tail_q == LAST) ? '0 : tail_q + 1'b1;
      end
      if (do_pop) begin
         head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
      end
      if (flush) begin
         head_d = '0;
         tail_d = '0;
         occ_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   assign rdata = mem_q[head_q];
   assign occ   = occ_q;
endmodule

// File: rtl/fetch_queue_unit.sv
// Prefetching fetch unit: credit-limited memory
// requests, in-order responses, flushable queue.
module fetch_queue_unit
   import fetch_queue_unit_pkg::*;
#(
   parameter int unsigned     XLEN     = XLEN_DEF,
   parameter int unsigned     ILEN     = ILEN_DEF,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            CLK,
   input  logic            RST_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [ILEN-1:0] imem_resp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            ir_valid,
   input  logic            ir_ready,
   output logic [ILEN-1:0] ir_instr,
   output logic [XLEN-1:0] ir_pc,
   output logic [XLEN-1:0] ir_pc_plus4
);
   localparam int unsigned     CW   = $clog2(DEPTH + 1);
   localparam int unsigned     FW   = ILEN + XLEN;
   localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);
   localparam logic [XLEN-1:0] MASK = ~XLEN'(3);
   localparam logic [XLEN-1:0] PC0  = RESET_PC & MASK;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [CW-1:0]   occ;
   logic [XLEN-1:0] redir_pc;
   logic [FW-1:0]   head;
   logic            credit, req_fire, pop;
   logic            resp_drop, resp_keep;

   assign redir_pc = redirect_pc & MASK;
   // outstanding plus buffered never exceeds DEPTH,
   // so a kept response always finds a free slot
   assign credit = (32'(inflight_q) + 32'(occ)) < 32'(DEPTH);

   assign imem_req_valid = credit & ~redirect_valid & RST_n;
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire  = imem_req_valid & imem_req_ready;
   assign resp_drop = imem_resp_valid & (drop_q != '0);
   assign resp_keep = imem_resp_valid & (drop_q == '0)
                    & ~redirect_valid;

   assign ir_valid = (occ != '0);
   assign pop      = ir_valid & ir_ready & ~redirect_valid;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      inflight_d = inflight_q + CW'(req_fire)
                 - CW'(imem_resp_valid);
      drop_d     = drop_q - CW'(resp_drop);
      unique case (1'b1)
         redirect_valid: fetch_pc_d = redir_pc;
         req_fire:       fetch_pc_d = fetch_pc_q + STEP;
         default:        ;
      endcase
      unique case (1'b1)
         redirect_valid: resp_pc_d = redir_pc;
         resp_keep:      resp_pc_d = resp_pc_q + STEP;
         default:        ;
      endcase
      // squash everything still outstanding after this cycle
      if (redirect_valid) begin
         drop_d = inflight_q - CW'(imem_resp_valid);
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         fetch_pc_q <= PC0;
         resp_pc_q  <= PC0;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   fetch_queue_unit_sync_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (RST_n),
      .flush (redirect_valid),
      .push  (resp_keep),
      .wdata ({imem_resp_data, resp_pc_q}),
      .pop   (pop),
      .rdata (head),
      .occ   (occ)
   );

   assign ir_instr    = head[FW-1:XLEN];
   assign ir_pc       = head[XLEN-1:0];
   assign ir_pc_plus4 = ir_pc + STEP;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed table,
// redirect/reset sequences, random memory model.
module tb_fetch_queue_unit;
   import fetch_queue_unit_pkg::*;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned ILEN  = 32;
   localparam int unsigned DEPTH = 4;
   localparam logic [63:0] RPC   = 64'h100;

   logic            CLK = 1'b0;
   logic            RST_n = 1'b1;
   logic            imem_req_valid;
   logic            imem_req_ready = 1'b0;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid = 1'b0;
   logic [ILEN-1:0] imem_resp_data = NOP_INSTR;
   logic            redirect_valid = 1'b0;
   logic [XLEN-1:0] redirect_pc = '0;
   logic            ir_valid;
   logic            ir_ready = 1'b0;
   logic [ILEN-1:0] ir_instr;
   logic [XLEN-1:0] ir_pc;
   logic [XLEN-1:0] ir_pc_plus4;

   always #5 CLK = ~CLK;

   fetch_queue_unit #(
      .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RPC)
   ) dut (
      .CLK(CLK), .RST_n(RST_n),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .ir_valid(ir_valid), .ir_ready(ir_ready),
      .ir_instr(ir_instr), .ir_pc(ir_pc),
      .ir_pc_plus4(ir_pc_plus4)
   );

   typedef struct {
      logic [63:0] addr;
      logic [31:0] data;
      int          due;
      bit          sq;
   } req_t;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } ent_t;

   typedef struct {
      bit          rst;
      bit          irr;
      bit          rv;
      logic [63:0] addr;
      bit          iv;
      logic [63:0] pc;
   } vec_t;

   req_t        mq[$];
   ent_t        iq[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          npops = 0;
   int          lat_lo = 1;
   int          lat_hi = 1;
   logic [63:0] exp_pc = RPC;
   bit          prev_stall = 0;
   logic [63:0] prev_addr = '0;
   bit          s_rv, s_iv;
   logic [63:0] s_addr, s_pc;
   vec_t        tbl[20];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic vec_t v(bit rst, bit irr, bit rv,
                              logic [63:0] a, bit iv,
                              logic [63:0] pc);
      vec_t r;
      r.rst = rst; r.irr = irr; r.rv = rv;
      r.addr = a; r.iv = iv; r.pc = pc;
      return r;
   endfunction

   task automatic do_reset();
      #2;
      RST_n = 1'b0;
      ir_ready = 1'b1;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data = NOP_INSTR;
      #1;
      chk("rst_ir_valid", ir_valid, 0);
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_req_addr", imem_req_addr, RPC);
      chk("rst_ir_pc", ir_pc, 0);
      chk("rst_ir_instr", ir_instr, 0);
      mq.delete();
      iq.delete();
      exp_pc = RPC;
      prev_stall = 0;
      @(negedge CLK);
      @(negedge CLK);
      RST_n = 1'b1;
   endtask

   // one cycle: drive at negedge, check against model, advance
   task automatic step(input bit irr, input bit rdy,
                       input bit rd, input logic [63:0] rpc);
      bit   rv, erv, popd;
      req_t e;
      ir_ready = irr;
      imem_req_ready = rdy;
      redirect_valid = rd;
      redirect_pc = rpc;
      rv = (mq.size() > 0) && (mq[0].due <= cyc);
      imem_resp_valid = rv;
      imem_resp_data = rv ? mq[0].data : NOP_INSTR;
      #1;
      erv = ((mq.size() + iq.size()) < DEPTH) && !rd;
      chk("req_valid", imem_req_valid, erv);
      if (erv) chk("req_addr", imem_req_addr, exp_pc);
      if (prev_stall && !rd)
         chk("addr_stable", imem_req_addr, prev_addr);
      chk("ir_valid", ir_valid, iq.size() > 0);
      if (iq.size() > 0) begin
         chk("ir_pc", ir_pc, iq[0].pc);
         chk("ir_instr", ir_instr, iq[0].instr);
         chk("ir_pc_plus4", ir_pc_plus4, iq[0].pc + 64'd4);
      end
      chk("invariant",
          (dut.drop_q <= dut.inflight_q) &&
          (dut.inflight_q <= DEPTH), 1);
      s_rv = imem_req_valid;
      s_addr = imem_req_addr;
      s_iv = ir_valid;
      s_pc = ir_pc;
      popd = (iq.size() > 0) && irr && !rd;
      if (popd) begin
         void'(iq.pop_front());
         npops++;
      end
      if (rv) begin
         e = mq.pop_front();
         if (!e.sq && !rd) iq.push_back('{e.addr, e.data});
      end
      prev_stall = erv && !rdy;
      prev_addr = exp_pc;
      if (rd) begin
         iq.delete();
         foreach (mq[i]) mq[i].sq = 1;
         exp_pc = {rpc[63:2], 2'b00};
      end else if (erv && rdy) begin
         e.addr = exp_pc;
         e.data = $urandom;
         e.due = cyc + int'($urandom_range(lat_hi, lat_lo));
         e.sq = 0;
         mq.push_back(e);
         exp_pc = exp_pc + 64'd4;
      end
      @(posedge CLK);
      @(negedge CLK);
      cyc++;
   endtask

   initial begin
      bit found;
      tbl[0]  = v(1, 1, 1, 64'h100, 0, 64'h0);
      tbl[1]  = v(0, 1, 1, 64'h104, 0, 64'h0);
      tbl[2]  = v(0, 1, 1, 64'h108, 1, 64'h100);
      tbl[3]  = v(0, 1, 1, 64'h10c, 1, 64'h104);
      tbl[4]  = v(0, 1, 1, 64'h110, 1, 64'h108);
      tbl[5]  = v(1, 0, 1, 64'h100, 0, 64'h0);
      tbl[6]  = v(0, 0, 1, 64'h104, 0, 64'h0);
      tbl[7]  = v(0, 0, 1, 64'h108, 1, 64'h100);
      tbl[8]  = v(0, 0, 1, 64'h10c, 1, 64'h100);
      for (int i = 9; i < 15; i++)
         tbl[i] = v(0, 0, 0, 64'h0, 1, 64'h100);
      tbl[15] = v(0, 1, 0, 64'h0, 1, 64'h100);
      tbl[16] = v(0, 1, 1, 64'h110, 1, 64'h104);
      tbl[17] = v(0, 1, 1, 64'h114, 1, 64'h108);
      tbl[18] = v(0, 1, 1, 64'h118, 1, 64'h10c);
      tbl[19] = v(0, 1, 1, 64'h11c, 1, 64'h110);

      lat_lo = 1;
      lat_hi = 1;
      for (int i = 0; i < 20; i++) begin
         if (tbl[i].rst) do_reset();
         step(tbl[i].irr, 1'b1, 1'b0, '0);
         chk($sformatf("tbl%0d_rv", i), s_rv, tbl[i].rv);
         if (tbl[i].rv)
            chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
         chk($sformatf("tbl%0d_iv", i), s_iv, tbl[i].iv);
         if (tbl[i].iv)
            chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].pc);
      end

      // redirect with three fetches in flight
      do_reset();
      lat_lo = 3;
      lat_hi = 3;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b1, 64'h2002);
      chk("redir_no_req", s_rv, 0);
      step(1'b1, 1'b1, 1'b0, '0);
      chk("redir_req_valid", s_rv, 1);
      chk("redir_req_addr", s_addr, 64'h2000);
      found = 0;
      for (int k = 0; k < 30 && !found; k++) begin
         step(1'b1, 1'b1, 1'b0, '0);
         if (s_iv) begin
            found = 1;
            chk("redir_first_pc", s_pc, 64'h2000);
         end
      end
      chk("redir_seen", found, 1);

      // redirect with response, pop and full credit together
      do_reset();
      lat_lo = 2;
      lat_hi = 2;
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, '0);
      step(1'b1, 1'b1, 1'b1, 64'h3000);
      chk("fullq_no_req", s_rv, 0);
      step(1'b1, 1'b1, 1'b0, '0);
      chk("fullq_flushed", s_iv, 0);
      chk("fullq_req_addr", s_addr, 64'h3000);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0);

      // reset with two in flight
      do_reset();
      lat_lo = 3;
      lat_hi = 3;
      step(1'b1, 1'b1, 1'b0, '0);
      step(1'b1, 1'b1, 1'b0, '0);
      do_reset();
      chk("mid_rst_inflight", dut.inflight_q, 0);
      chk("mid_rst_drop", dut.drop_q, 0);
      step(1'b1, 1'b1, 1'b0, '0);
      chk("mid_rst_restart_v", s_rv, 1);
      chk("mid_rst_restart_a", s_addr, RPC);

      // random ready, latency, consumer stalls and redirects
      do_reset();
      lat_lo = 1;
      lat_hi = 5;
      npops = 0;
      for (int k = 0; k < 20000 && npops < 1000; k++) begin
         step($urandom_range(3, 0) != 0,
              $urandom_range(1, 0) == 1,
              $urandom_range(63, 0) == 0,
              {$urandom, $urandom});
      end
      chk("rand_done", npops >= 1000, 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
